// File: rtl/uart_payload_buffer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_payload_buffer_if                                           |
// | Brief    : UART byte stream in, UDP payload frame handshake out.            |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface uart_payload_buffer_if #(
  parameter int PAYLOAD_BYTES = 8
);
  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic                       eth_ready;
  logic [PAYLOAD_BYTES*8-1:0] data;
  logic [15:0]                size;
  logic                       send;
  logic                       overflow;

  // master: the payload buffer itself
  modport master (
    input  rx_data, rx_valid, eth_ready,
    output data, size, send, overflow
  );

  // slave: the surrounding UART receiver / UDP transmitter side
  modport slave (
    output rx_data, rx_valid, eth_ready,
    input  data, size, send, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_payload_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_payload_buffer                                              |
// | Brief    : Double-buffered packer of UART bytes into fixed UDP payloads.    |
// |            Define PAYLOAD_TIMEOUT_FLUSH_EN to flush partial frames on idle. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module uart_payload_buffer #(
  parameter int PAYLOAD_BYTES  = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input wire logic             clk,
  input wire logic             reset,
  uart_payload_buffer_if.master bus
);
  localparam int DATA_W = PAYLOAD_BYTES * 8;
  localparam int CNT_W  = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_BUSY     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       size_q, size_d;
  logic              overflow_q, overflow_d;
  logic              send_w;
  logic              fill_full;
  logic              flush_req;
  logic              transfer;
  logic              wr_en;
  logic [CNT_W-1:0]  wr_idx;

  assign fill_full = (count_q == CNT_FULL);
  assign transfer  = (state_q == ST_EMPTY) && (fill_full || flush_req);

  // A byte arriving in the transfer cycle lands in slot 0 of the freshly emptied buffer.
  assign wr_en  = bus.rx_valid && (transfer || !fill_full);
  assign wr_idx = transfer ? '0 : count_q;

`ifdef PAYLOAD_TIMEOUT_FLUSH_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              partial;

  assign partial   = (count_q != '0) && !fill_full;
  assign flush_req = partial && (idle_q == IDLE_LAST);

  // Saturating at IDLE_LAST keeps the flush request pending while the slot is busy.
  always_comb begin
    idle_d = idle_q;
    if (bus.rx_valid || transfer) begin
      idle_d = '0;
    end else if (partial && (idle_q != IDLE_LAST)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign flush_req = 1'b0;
`endif

  always_comb begin
    fill_d     = fill_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (transfer) begin
      fill_d  = '0;
      count_d = '0;
    end
    if (wr_en) begin
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
        if (wr_idx == CNT_W'(i)) begin
          fill_d[(PAYLOAD_BYTES-1-i)*8 +: 8] = bus.rx_data;
        end
      end
      count_d = (transfer ? '0 : count_q) + 1'b1;
    end else if (bus.rx_valid) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    data_d = data_q;
    size_d = size_q;
    if (transfer) begin
      data_d = fill_q;
      size_d = 16'(count_q);
    end
  end

  always_comb begin
    state_d = state_q;
    send_w  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (transfer) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (bus.eth_ready) begin
          send_w  = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!bus.eth_ready) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.eth_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      fill_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      size_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      data_q     <= data_d;
      size_q     <= size_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.data     = data_q;
  assign bus.size     = size_q;
  assign bus.send     = send_w;
  assign bus.overflow = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_payload_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_uart_payload_buffer                                           |
// | Brief    : Directed and random checks of uart_payload_buffer vs a model.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_payload_buffer;
  localparam int P = 8;
`ifdef PAYLOAD_TIMEOUT_FLUSH_EN
  localparam int TO  = 16;
  localparam bit TEN = 1'b1;
`else
  localparam int TO  = 100000;
  localparam bit TEN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_payload_buffer_if #(.PAYLOAD_BYTES(P)) bus ();

  uart_payload_buffer #(
    .PAYLOAD_BYTES (P),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;
  int n_sends = 0;
  int last_send_cyc = -1;
  logic [63:0] sent_data = '0;
  logic [15:0] sent_size = '0;

  // Reference model: byte queue for the fill side, one frame slot with a handshake phase
  // (0 free, 1 waiting to send, 2 waiting for ready to drop, 3 waiting for ready to rise).
  logic [7:0]  m_fill[$];
  logic [63:0] m_data;
  int          m_size;
  int          m_phase;
  bit          m_ovf;
  int          m_idle;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack8(input logic [7:0] a[8]);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[(7-i)*8 +: 8] = a[i];
    return r;
  endfunction

  task automatic model_reset();
    m_fill.delete();
    m_data  = '0;
    m_size  = 0;
    m_phase = 0;
    m_ovf   = 1'b0;
    m_idle  = 0;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit er);
    bit exp_send, trig, flush;
    int cnt0;
    @(negedge clk);
    bus.rx_valid  = v;
    bus.rx_data   = d;
    bus.eth_ready = er;
    #1;
    exp_send = (m_phase == 1) && er;
    chk("send", 64'(bus.send), 64'(exp_send));
    chk("data", bus.data, m_data);
    chk("size", 64'(bus.size), 64'(m_size));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    if (bus.send === 1'b1) begin
      n_sends++;
      last_send_cyc = cyc;
      sent_data = bus.data;
      sent_size = bus.size;
    end
    cnt0  = m_fill.size();
    flush = TEN && (cnt0 > 0) && (m_idle == TO - 1);
    trig  = (m_phase == 0) && ((cnt0 == P) || flush);
    case (m_phase)
      1: if (er)  m_phase = 2;
      2: if (!er) m_phase = 3;
      3: if (er)  m_phase = 0;
      default: ;
    endcase
    if (trig) begin
      m_data = '0;
      foreach (m_fill[i]) m_data[(P-1-i)*8 +: 8] = m_fill[i];
      m_size = cnt0;
      m_fill.delete();
      m_phase = 1;
    end
    if (v) begin
      if (m_fill.size() < P) m_fill.push_back(d);
      else m_ovf = 1'b1;
    end
    if (v || trig) m_idle = 0;
    else if (cnt0 > 0 && cnt0 < P && m_idle < TO - 1) m_idle++;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    #1;
    chk("rst_data", bus.data, 64'd0);
    chk("rst_size", 64'(bus.size), 64'd0);
    chk("rst_send", 64'(bus.send), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic feed(input logic [7:0] a[8], input int n, input bit er);
    for (int i = 0; i < n; i++) step(1'b1, a[i], er);
  endtask

  // Transmitter acceptance: hold ready, drop it, then raise it to free the slot.
  task automatic ack();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1[8];
    logic [7:0] b[8];
    logic [7:0] c[8];
    logic [7:0] x;
    int s0, t8;
    bit v, er;

    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.eth_ready = 1'b1;
    model_reset();
    do_reset();

    // T1: nominal frame and latency
    t1 = '{8'hF0, 8'h55, 8'h72, 8'h48, 8'h11, 8'h60, 8'h0C, 8'hF0};
    s0 = n_sends;
    feed(t1, 8, 1'b1);
    t8 = cyc - 1;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_latency", 64'(last_send_cyc), 64'(t8 + 2));
    chk("t1_sends", 64'(n_sends - s0), 64'd1);
    chk("t1_data", sent_data, 64'hF055724811600CF0);
    chk("t1_size", 64'(sent_size), 64'd8);
    ack();

    // T2: transmitter not ready holds the frame
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    s0 = n_sends;
    feed(b, 8, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
    chk("t2_nosend", 64'(n_sends - s0), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("t2_sends", 64'(n_sends - s0), 64'd1);
    chk("t2_data", sent_data, pack8(b));
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // T3: fill while busy, ninth byte dropped
    feed(t1, 8, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    feed(b, 8, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t3_ovf_before", 64'(bus.overflow), 64'd0);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t3_ovf_after", 64'(bus.overflow), 64'd1);
    s0 = n_sends;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("t3_sends", 64'(n_sends - s0), 64'd1);
    chk("t3_data", sent_data, pack8(b));
    chk("t3_size", 64'(sent_size), 64'd8);
    ack();

    // T4: byte in the transfer cycle starts the next frame
    do_reset();
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    x = 8'($urandom);
    feed(b, 8, 1'b0);
    step(1'b1, x, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_frame1", sent_data, pack8(b));
    ack();
    c[0] = x;
    for (int i = 1; i < 8; i++) c[i] = 8'($urandom);
    for (int i = 1; i < 8; i++) step(1'b1, c[i], 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_frame2", sent_data, pack8(c));
    chk("t4_overflow", 64'(bus.overflow), 64'd0);
    ack();

    // T6: asynchronous reset mid-handshake with a partial fill
    do_reset();
    feed(t1, 8, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    feed(t1, 3, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    s0 = n_sends;
    feed(b, 8, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_sends", 64'(n_sends - s0), 64'd1);
    chk("t6_data", sent_data, pack8(b));
    chk("t6_size", 64'(sent_size), 64'd8);
    ack();

`ifdef PAYLOAD_TIMEOUT_FLUSH_EN
    // T5: idle flush of a two-byte partial frame
    do_reset();
    step(1'b1, 8'hAA, 1'b1);
    step(1'b1, 8'hBB, 1'b1);
    t8 = cyc - 1;
    s0 = n_sends;
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
    chk("t5_sends", 64'(n_sends - s0), 64'd1);
    chk("t5_latency", 64'(last_send_cyc), 64'(t8 + 17));
    chk("t5_size", 64'(sent_size), 64'd2);
    chk("t5_data", sent_data, 64'hAABB000000000000);
    ack();
`endif

    // Random traffic against the model
    do_reset();
    er = 1'b1;
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 99) < 55);
      if ($urandom_range(0, 99) < 15) er = ~er;
      step(v, 8'($urandom), er);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
